lfsr_enc_ctrl: RTL and testbench

- Sequencing stage that owns the LFSR: it loads the LFSR, steps it one position per output byte, and XORs the keystream onto a byte stream to produce ciphertext.
- Each message is a configurable run of preamble characters followed by the plaintext bytes.
- Sits between the message source (upstream, valid/ready) and the ciphertext sink (downstream, valid/ready).
- Connects to the LFSR through that block's init/en/tab/init_state/state_o ports.

---
 rtl/lfsr_enc_pkg.sv | 7 +
 rtl/lfsr_enc_ctrl_if.sv | 39 +++
 rtl/lfsr_enc_cnt.sv | 27 ++
 rtl/lfsr_enc_ctrl.sv | 102 ++++++++++
 tb/tb_lfsr_enc_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/lfsr_enc_pkg.sv
// Shared types and defaults for the LFSR stream-encryption controller.
package lfsr_enc_pkg;
    localparam int         LEN_W_DEF    = 6;
    localparam logic [7:0] PRE_CHAR_DEF = 8'h20;

    typedef enum logic [2:0] {IDLE, LOAD, PRE, MSG, FIN} enc_state_t;
endpackage

// File: rtl/lfsr_enc_ctrl_if.sv
// Bundle of control, upstream/downstream stream and LFSR-side signals of lfsr_enc_ctrl.
interface lfsr_enc_ctrl_if import lfsr_enc_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF
);
    logic             start;
    logic [7:0]       cfg_tap;
    logic [7:0]       cfg_seed;
    logic [LEN_W-1:0] cfg_pre_len;
    logic [LEN_W-1:0] cfg_msg_len;
    logic             pt_valid;
    logic             pt_ready;
    logic [7:0]       pt_data;
    logic             ct_valid;
    logic             ct_ready;
    logic [7:0]       ct_data;
    logic             lfsr_init;
    logic             lfsr_en;
    logic [7:0]       lfsr_tab;
    logic [7:0]       lfsr_init_state;
    logic [7:0]       lfsr_state;
    logic             busy;
    logic             done;

    // Controller side
    modport master (
        input  start, cfg_tap, cfg_seed, cfg_pre_len, cfg_msg_len,
               pt_valid, pt_data, ct_ready, lfsr_state,
        output pt_ready, ct_valid, ct_data, lfsr_init, lfsr_en,
               lfsr_tab, lfsr_init_state, busy, done
    );

    // Environment side: message source, ciphertext sink and LFSR
    modport slave (
        output start, cfg_tap, cfg_seed, cfg_pre_len, cfg_msg_len,
               pt_valid, pt_data, ct_ready, lfsr_state,
        input  pt_ready, ct_valid, ct_data, lfsr_init, lfsr_en,
               lfsr_tab, lfsr_init_state, busy, done
    );
endinterface

// File: rtl/lfsr_enc_cnt.sv
// Beat counter: cleared before a phase, bumped per handshake, flags the final beat.
module lfsr_enc_cnt import lfsr_enc_pkg::*; #(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             last_o
);
    logic [LEN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Only consulted while the phase is active, so len_i is never 0 here.
    assign last_o = (cnt_q == len_i - LEN_W'(1));
endmodule

// File: rtl/lfsr_enc_ctrl.sv
// Loads/steps an external LFSR and XORs its state onto preamble + plaintext bytes.
// Optional LFSR_ENC_ASCII7_EN: keystream bit 7 masked so ct_data[7] equals plaintext bit 7.
module lfsr_enc_ctrl import lfsr_enc_pkg::*; #(
    parameter int         LEN_W    = LEN_W_DEF,
    parameter logic [7:0] PRE_CHAR = PRE_CHAR_DEF
) (
    input logic             clk,
    input logic             rst_n,
    lfsr_enc_ctrl_if.master bus
);
    enc_state_t       state_q, state_d;
    logic [7:0]       tap_q, seed_q;
    logic [LEN_W-1:0] pre_len_q, msg_len_q;
    logic             accept, pre_hs, msg_hs, pre_last, msg_last, cnt_clr;
    logic [7:0]       ks;

    assign accept  = (state_q == IDLE) && bus.start;
    assign pre_hs  = (state_q == PRE) && bus.ct_ready;
    assign msg_hs  = (state_q == MSG) && bus.pt_valid && bus.ct_ready;
    assign cnt_clr = (state_q == LOAD);

`ifdef LFSR_ENC_ASCII7_EN
    assign ks = bus.lfsr_state & 8'h7F;
`else
    assign ks = bus.lfsr_state;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q     <= '0;
            seed_q    <= '0;
            pre_len_q <= '0;
            msg_len_q <= '0;
        end else if (accept) begin
            tap_q     <= bus.cfg_tap;
            seed_q    <= bus.cfg_seed;
            pre_len_q <= bus.cfg_pre_len;
            msg_len_q <= bus.cfg_msg_len;
        end
    end

    lfsr_enc_cnt #(.LEN_W(LEN_W)) u_pre_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(pre_hs),
        .len_i(pre_len_q), .last_o(pre_last)
    );

    lfsr_enc_cnt #(.LEN_W(LEN_W)) u_msg_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .en_i(msg_hs),
        .len_i(msg_len_q), .last_o(msg_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Zero-length phases are skipped entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: begin
                if (pre_len_q != '0)      state_d = PRE;
                else if (msg_len_q != '0) state_d = MSG;
                else                      state_d = FIN;
            end
            PRE:  if (pre_hs && pre_last) state_d = (msg_len_q != '0) ? MSG : FIN;
            MSG:  if (msg_hs && msg_last) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pt_ready  = 1'b0;
        bus.ct_valid  = 1'b0;
        bus.ct_data   = 8'h00;
        bus.lfsr_init = 1'b0;
        bus.lfsr_en   = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        case (state_q)
            LOAD: bus.lfsr_init = 1'b1;
            PRE: begin
                bus.ct_valid = 1'b1;
                bus.ct_data  = PRE_CHAR ^ ks;
                bus.lfsr_en  = pre_hs;
            end
            MSG: begin
                bus.ct_valid = bus.pt_valid;
                bus.pt_ready = bus.ct_ready;
                bus.ct_data  = bus.pt_data ^ ks;
                bus.lfsr_en  = msg_hs;
            end
            FIN:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.lfsr_tab        = tap_q;
    assign bus.lfsr_init_state = seed_q;
endmodule

// File: tb/tb_lfsr_enc_ctrl.sv
// Randomized bench for lfsr_enc_ctrl: behavioural LFSR plus per-message keystream/ciphertext model.
module tb_lfsr_enc_ctrl;
    import lfsr_enc_pkg::*;

`ifdef LFSR_ENC_ASCII7_EN
    localparam logic [7:0] KM = 8'h7F;
`else
    localparam logic [7:0] KM = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_enc_ctrl_if #(.LEN_W(6)) bus ();
    lfsr_enc_ctrl #(.LEN_W(6), .PRE_CHAR(8'h20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_pass = 0, en_cnt = 0;
    logic [7:0] pt [0:127];
    logic [7:0] exp_ct [0:127];
    logic [7:0] obs [0:127];

    // External LFSR: right shift, parity of tapped bits fed into bit 7, no reset.
    function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] t);
        return {^(s & t), s[7:1]};
    endfunction

    logic [7:0] ls;
    always @(posedge clk) begin
        if (bus.lfsr_init)    ls <= bus.lfsr_init_state;
        else if (bus.lfsr_en) ls <= step(ls, bus.lfsr_tab);
    end
    assign bus.lfsr_state = ls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_ctv"},   32'(bus.ct_valid), 0);
        chk({tag, "_ptr"},   32'(bus.pt_ready), 0);
        chk({tag, "_init"},  32'(bus.lfsr_init), 0);
        chk({tag, "_en"},    32'(bus.lfsr_en), 0);
        chk({tag, "_done"},  32'(bus.done), 0);
        chk({tag, "_ctd"},   32'(bus.ct_data), 0);
    endtask

    // mode 0: always ready/valid, 1: random stalls, 2: ct_ready pattern 1,0,0,1,1 then 1
    task automatic run_msg(input logic [7:0] tap, input logic [7:0] seed, input int pre,
                           input int msg, input int mode, input bit rand_pt, input int abort_b);
        int total, b, ph, pc;
        bit e_valid, e_ptr, fin;
        logic [7:0] k;
        logic [4:0] pat;
        pat = 5'b11001;  // read LSB-first: 1,0,0,1,1
        total = pre + msg;
        if (rand_pt) for (int i = 0; i < msg; i++) pt[i] = 8'($urandom);
        k = seed;
        for (int i = 0; i < total; i++) begin
            exp_ct[i] = ((i < pre) ? 8'h20 : pt[i-pre]) ^ (k & KM);
            k = step(k, tap);
        end
        en_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_tap = tap; bus.cfg_seed = seed;
        bus.cfg_pre_len = 6'(pre); bus.cfg_msg_len = 6'(msg);
        @(posedge clk); #1;
        bus.start = 1'b0;
        ph = 0; b = 0; pc = 0; fin = 0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            // Start and cfg inputs churn while busy; both must be ignored.
            bus.start       = (ph != 3) ? 1'($urandom) : 1'b0;
            bus.cfg_tap     = 8'($urandom);
            bus.cfg_seed    = 8'($urandom);
            bus.cfg_pre_len = 6'($urandom);
            bus.cfg_msg_len = 6'($urandom);
            if (mode == 0)      bus.ct_ready = 1'b1;
            else if (mode == 1) bus.ct_ready = 1'($urandom);
            else                bus.ct_ready = (ph == 1 && pc < 5) ? pat[pc] : 1'b1;
            bus.pt_valid = (mode == 0) ? 1'b1 : 1'($urandom);
            bus.pt_data  = (ph == 1 && b >= pre && b < total) ? pt[b-pre] : 8'($urandom);
            if (ph == 1 && b == abort_b) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1 chk_idle_outs("abort");
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
                chk("abort_after_busy", 32'(bus.busy), 0);
                chk("abort_after_done", 32'(bus.done), 0);
                return;
            end
            @(negedge clk);
            e_valid = (ph == 1) && ((b < pre) || bus.pt_valid);
            e_ptr   = (ph == 1) && (b >= pre) && bus.ct_ready;
            chk("busy",     32'(bus.busy),      32'(ph != 3));
            chk("init",     32'(bus.lfsr_init), 32'(ph == 0));
            chk("done",     32'(bus.done),      32'(ph == 2));
            chk("ct_valid", 32'(bus.ct_valid),  32'(e_valid));
            chk("pt_ready", 32'(bus.pt_ready),  32'(e_ptr));
            chk("lfsr_en",  32'(bus.lfsr_en),   32'(e_valid && bus.ct_ready));
            if (e_valid) chk("ct_data", 32'(bus.ct_data), 32'(exp_ct[b]));
            if (ph == 3) chk("idle_ct_data", 32'(bus.ct_data), 0);
            if (bus.lfsr_en) en_cnt++;
            case (ph)
                0: ph = (total != 0) ? 1 : 2;
                1: begin
                    pc++;
                    if (e_valid && bus.ct_ready) begin
                        obs[b] = bus.ct_data;
                        b++;
                        if (b == total) ph = 2;
                    end
                end
                2: ph = 3;
                default: fin = 1;
            endcase
            if (!fin) begin @(posedge clk); #1; end
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    initial begin
        bus.start = 0; bus.cfg_tap = 0; bus.cfg_seed = 0; bus.cfg_pre_len = 0; bus.cfg_msg_len = 0;
        bus.pt_valid = 0; bus.pt_data = 0; bus.ct_ready = 0;
        #12 chk_idle_outs("reset");
        chk("reset_tab", 32'(bus.lfsr_tab), 0);
        chk("reset_seed", 32'(bus.lfsr_init_state), 0);
        rst_n = 1'b1;

        run_msg(8'hB8, 8'hFF, 3, 0, 0, 1'b1, -1);
        chk("pre_lit0", 32'(obs[0]), 32'((KM == 8'hFF) ? 8'hDF : 8'h5F));
        chk("pre_lit1", 32'(obs[1]), 32'(8'h5F));
        chk("pre_lit2", 32'(obs[2]), 32'((KM == 8'hFF) ? 8'h9F : 8'h1F));

        pt[0] = 8'h41; pt[1] = 8'h42;
        run_msg(8'hB8, 8'hFF, 0, 2, 0, 1'b0, -1);
        chk("msg_lit0", 32'(obs[0]), 32'((KM == 8'hFF) ? 8'hBE : 8'h3E));
        chk("msg_lit1", 32'(obs[1]), 32'(8'h3D));

        run_msg(8'hB8, 8'hFF, 3, 0, 2, 1'b1, -1);
        chk("stall_en_pulses", 32'(en_cnt), 3);

        run_msg(8'hB8, 8'hFF, 0, 0, 0, 1'b1, -1);
        chk("empty_en_pulses", 32'(en_cnt), 0);

        run_msg(8'hB8, 8'h5A, 0, 5, 1, 1'b1, 1);
        pt[0] = 8'h00;
        run_msg(8'hB8, 8'hFF, 0, 1, 0, 1'b0, -1);
        chk("replay_lit", 32'(obs[0]), 32'(KM));

        run_msg(8'hB8, 8'hFF, 1, 0, 0, 1'b1, -1);
        chk("pre1_lit", 32'(obs[0]), 32'((KM == 8'hFF) ? 8'hDF : 8'h5F));

        for (int m = 0; m < 30; m++)
            run_msg(8'($urandom_range(1, 255)), 8'($urandom), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 63)), 1, 1'b1, -1);
        run_msg(8'h8E, 8'h01, 63, 63, 1, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
